// File: rtl/tcdm_stream_reader_if.sv
// rtl/tcdm_stream_reader_if.sv - config, TCDM requester and output stream bundle for tcdm_stream_reader
interface tcdm_stream_reader_if #(
   parameter int NarrowDataWidth = 64,
   parameter int TCDMAddrWidth   = 12,
   parameter int LenWidth        = 16
);
   logic                         cfg_valid_i;
   logic                         cfg_ready_o;
   logic [TCDMAddrWidth-1:0]     cfg_base_i;
   logic [TCDMAddrWidth-1:0]     cfg_stride_i;
   logic [LenWidth-1:0]          cfg_len_i;

   logic                         tcdm_req_write_o;
   logic [TCDMAddrWidth-1:0]     tcdm_req_addr_o;
   logic [3:0]                   tcdm_req_amo_o;
   logic [NarrowDataWidth-1:0]   tcdm_req_data_o;
   logic [4:0]                   tcdm_req_user_core_id_o;
   logic                         tcdm_req_user_is_core_o;
   logic [NarrowDataWidth/8-1:0] tcdm_req_strb_o;
   logic                         tcdm_req_q_valid_o;
   logic                         tcdm_rsp_q_ready_i;
   logic                         tcdm_rsp_p_valid_i;
   logic [NarrowDataWidth-1:0]   tcdm_rsp_data_i;

   logic [NarrowDataWidth-1:0]   out_data_o;
   logic                         out_valid_o;
   logic                         out_ready_i;

   logic                         busy_o;
   logic                         done_o;

   // Reader side: issues requests, owns the stream.
   modport master (
      input  cfg_valid_i, cfg_base_i, cfg_stride_i, cfg_len_i,
      input  tcdm_rsp_q_ready_i, tcdm_rsp_p_valid_i, tcdm_rsp_data_i,
      input  out_ready_i,
      output cfg_ready_o,
      output tcdm_req_write_o, tcdm_req_addr_o, tcdm_req_amo_o, tcdm_req_data_o,
      output tcdm_req_user_core_id_o, tcdm_req_user_is_core_o, tcdm_req_strb_o,
      output tcdm_req_q_valid_o,
      output out_data_o, out_valid_o, busy_o, done_o
   );

   // Environment side: configures, serves TCDM, consumes the stream.
   modport slave (
      output cfg_valid_i, cfg_base_i, cfg_stride_i, cfg_len_i,
      output tcdm_rsp_q_ready_i, tcdm_rsp_p_valid_i, tcdm_rsp_data_i,
      output out_ready_i,
      input  cfg_ready_o,
      input  tcdm_req_write_o, tcdm_req_addr_o, tcdm_req_amo_o, tcdm_req_data_o,
      input  tcdm_req_user_core_id_o, tcdm_req_user_is_core_o, tcdm_req_strb_o,
      input  tcdm_req_q_valid_o,
      input  out_data_o, out_valid_o, busy_o, done_o
   );
endinterface

// File: rtl/tcdm_stream_reader.sv
// rtl/tcdm_stream_reader.sv - strided TCDM read requester feeding a credit-protected stream FIFO
module tcdm_stream_reader #(
   parameter int         NarrowDataWidth = 64,
   parameter int         TCDMAddrWidth   = 12,
   parameter int         FifoDepth       = 4,
   parameter int         LenWidth        = 16,
   parameter logic [4:0] CoreId          = 5'd0
) (
   input logic                 clk_i,
   input logic                 rst_i,
   tcdm_stream_reader_if.master bus
);

   localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0] Depth = CntW'(FifoDepth);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

   state_e                     state_q;
   logic [TCDMAddrWidth-1:0]   addr_q;
   logic [TCDMAddrWidth-1:0]   stride_q;
   logic [LenWidth-1:0]        len_q;
   logic [LenWidth-1:0]        req_cnt_q;
   logic [LenWidth-1:0]        pop_cnt_q;
   logic                       done_q;

   // credits = requests in flight + words sitting in the FIFO
   logic [CntW-1:0]            credits_q;
   logic [CntW-1:0]            fifo_cnt_q;
   logic [PtrW-1:0]            wptr_q;
   logic [PtrW-1:0]            rptr_q;
   logic [NarrowDataWidth-1:0] mem_q [FifoDepth];

   logic                       q_valid;
   logic                       req_hs;
   logic                       cfg_fire;
   logic                       fifo_empty;
   logic                       fifo_full;
   logic                       push;
   logic                       pop;
   logic [LenWidth-1:0]        last_idx;

   assign q_valid    = (state_q == ISSUE) && (credits_q < Depth);
   assign req_hs     = q_valid && bus.tcdm_rsp_q_ready_i;
   assign cfg_fire   = bus.cfg_valid_i && (state_q == IDLE);
   assign fifo_empty = (fifo_cnt_q == '0);
   assign fifo_full  = (fifo_cnt_q == Depth);
   // A response is only accepted if some request is still outstanding; this
   // drops stragglers from a transfer that was cut short by reset.
   assign push       = bus.tcdm_rsp_p_valid_i && (fifo_cnt_q < credits_q);
   assign pop        = !fifo_empty && bus.out_ready_i;
   assign last_idx   = len_q - LenWidth'(1);

   // Transfer sequencing: address walk, request/pop counting, completion pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         stride_q  <= '0;
         len_q     <= '0;
         req_cnt_q <= '0;
         pop_cnt_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (pop) pop_cnt_q <= pop_cnt_q + LenWidth'(1);
         case (state_q)
            IDLE: begin
               if (cfg_fire) begin
                  stride_q  <= bus.cfg_stride_i;
                  len_q     <= bus.cfg_len_i;
                  req_cnt_q <= '0;
                  pop_cnt_q <= '0;
                  if (bus.cfg_len_i == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     addr_q  <= bus.cfg_base_i;
                     state_q <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (req_hs) begin
                  addr_q    <= addr_q + stride_q;
                  req_cnt_q <= req_cnt_q + LenWidth'(1);
                  if (req_cnt_q == last_idx) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop_cnt_q == len_q) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Credit and FIFO occupancy bookkeeping
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         credits_q  <= '0;
         fifo_cnt_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         case ({req_hs, pop})
            2'b10:   credits_q <= credits_q + CntW'(1);
            2'b01:   credits_q <= credits_q - CntW'(1);
            default: credits_q <= credits_q;
         endcase
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
         if (push) wptr_q <= wptr_q + PtrW'(1);
         if (pop)  rptr_q <= rptr_q + PtrW'(1);
      end
   end

   // FIFO storage; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= bus.tcdm_rsp_data_i;
   end

   assert property (@(posedge clk_i) disable iff (rst_i) !(bus.tcdm_rsp_p_valid_i && fifo_full));

   assign bus.cfg_ready_o             = (state_q == IDLE);
   assign bus.busy_o                  = (state_q != IDLE);
   assign bus.done_o                  = done_q;
   assign bus.tcdm_req_q_valid_o      = q_valid;
   assign bus.tcdm_req_addr_o         = addr_q;
   assign bus.tcdm_req_write_o        = 1'b0;
   assign bus.tcdm_req_amo_o          = 4'h0;
   assign bus.tcdm_req_data_o         = '0;
   assign bus.tcdm_req_user_core_id_o = CoreId;
   assign bus.tcdm_req_user_is_core_o = 1'b0;
   assign bus.tcdm_req_strb_o         = '1;
   assign bus.out_valid_o             = !fifo_empty;
   assign bus.out_data_o              = mem_q[rptr_q];

endmodule
